lc3b_hazard_ctrl: RTL and testbench
===================================

# lc3b_hazard_ctrl

Pipeline hazard and stall controller for the five-stage LC-3b core. It consumes the destination and control fields that the ID/EX pipeline register presents to execute. It also consumes the IF/ID source fields and the instruction- and data-memory handshakes. From these it drives the load enables, flushes and bubble insertion of PC, IF/ID, ID/EX, EX/MEM and MEM/WB. A small FSM tracks data-memory freezes and wrong-path fetch drains, and saturating counters record stall and flush activity.

## Interface
Parameters:
- CNT_W, 16, width of performance counters

Ports:
- clk  in  1  core clock
- reset_n  in  1  asynchronous active-low reset
- ifid_sr1, ifid_sr2  in  3 each  source registers of the instruction in IF/ID
- ifid_uses_sr1, ifid_uses_sr2  in  1 each  source actually read
- idex_dest  in  3  destination register held in ID/EX
- idex_load_regfile, idex_mem_read  in  1 each  control-word fields held in ID/EX
- exmem_mem_req  in  1  EX/MEM instruction accesses data memory (read or write)
- dmem_resp  in  1  data-memory access complete
- imem_resp  in  1  instruction fetch complete; level-held while the fetch address is stable
- br_taken  in  1  taken branch/jump resolved in MEM (one-cycle pulse per instruction)
- pc_load, ifid_load, idex_load, exmem_load, memwb_load  out  1 each  register enables
- ifid_flush, idex_flush, exmem_flush  out  1 each  load NOP control word instead of input
- idex_bubble  out  1  ID/EX loads NOP (load-use bubble)
- redirect_pending  out  1  PC mux selects the latched branch target
- stall_cycles, flush_count  out  CNT_W each  saturating performance counters

## Operation
- FSM states: RUN, DMEM_WAIT, IMEM_DRAIN. The FSM resets to RUN.
- Rules are evaluated in the current cycle in priority order. Unlisted enables are 1; unlisted flushes and bubbles are 0.
- Rule 1, dmem freeze (RUN or DMEM_WAIT): exmem_mem_req & !dmem_resp.
  - All five enables are 0; all flushes are 0.
  - Next state is DMEM_WAIT.
  - In DMEM_WAIT with dmem_resp=1, rules 2–4 are evaluated as in RUN, and the next state comes from those rules.
- Rule 2, branch (RUN): br_taken.
  - ifid_flush, idex_flush and exmem_flush are 1.
  - flush_count increments.
  - If imem_resp=1: pc_load=1, redirect_pending=1, next state RUN.
  - Otherwise: pc_load=0, next state IMEM_DRAIN.
- Rule 3, load-use (RUN): idex_mem_read & idex_load_regfile & ((ifid_uses_sr1 & ifid_sr1==idex_dest) | (ifid_uses_sr2 & ifid_sr2==idex_dest)).
  - pc_load=0, ifid_load=0, idex_bubble=1.
- Rule 4, fetch wait (RUN): !imem_resp.
  - pc_load=0, ifid_flush=1.
- IMEM_DRAIN:
  - redirect_pending=1 and ifid_flush=1; back-end enables are 1.
  - Load-use detection is masked.
  - While imem_resp=0: pc_load=0.
  - On imem_resp=1: the wrong-path word is discarded, pc_load=1, next state RUN.
- br_taken in DMEM_WAIT or IMEM_DRAIN cannot occur; the bench asserts it never does.
- stall_cycles increments every non-reset cycle with pc_load=0. flush_count increments per accepted br_taken. Both saturate at all-ones.

## Timing
- Reset (reset_n low, asynchronous): state RUN, counters 0.
  - All enables, flushes, idex_bubble and redirect_pending are forced to 0 while reset_n is low.
- Enables, flushes and bubbles are combinational from the current state and inputs, with zero-cycle latency into the pipeline registers at the next clk edge.
- The state and counters update at posedge clk.
- A load-use stall lasts exactly one cycle: on the next cycle the load has left ID/EX.
- The minimum branch penalty is 3 flushed slots with 0 drain cycles.
- Reset asserted mid-drain or mid-freeze returns the block to RUN with no pending redirect.

## Structure
- The state enum lc3b_hz_state and the NOP control-word constant belong in lc3b_types, next to lc3b_control_word and lc3b_reg.
- One sub-module, lc3b_sat_counter (parameterised width, increment, synchronous clear, async reset_n), instantiated twice.

## Test plan
- Load-use: idex_dest=3, idex_mem_read=1, idex_load_regfile=1, ifid_sr1=3, ifid_uses_sr1=1.
  - Expect one cycle of pc_load=0, ifid_load=0, idex_bubble=1, then all enables 1; stall_cycles=1.
- No false hazard: the same setup with ifid_uses_sr1=0, or with idex_mem_read=0.
  - Expect no stall.
- Dmem freeze: exmem_mem_req=1, dmem_resp=0 for 4 cycles, with br_taken=0 and load-use also present.
  - Expect all enables 0 for 4 cycles and state DMEM_WAIT.
  - On the resp cycle, the load-use stall applies; stall_cycles=5.
- Branch with fetch ready: br_taken=1, imem_resp=1.
  - Expect 3 flushes, pc_load=1, redirect_pending=1 for one cycle; flush_count=1.
- Branch during fetch miss: br_taken=1, imem_resp=0, then imem_resp=1 after 3 cycles.
  - Expect IMEM_DRAIN for 3 cycles with redirect_pending=1 and ifid_flush=1 throughout.
  - Then pc_load=1 and return to RUN.
- Async reset mid-IMEM_DRAIN.
  - Outputs are 0 immediately; state RUN and counters 0 after release.
  - Also pre-load stall_cycles to 0xFFFE and stall 3 cycles: expect a hold at 0xFFFF.

Source files
------------

// File: rtl/lc3b_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lc3b_types (package)
// Purpose  : Shared LC-3b pipeline types: register index, control word,
//            NOP control word, hazard FSM states and hazard-control bundle.
// Revision : 1.0 - initial release
// ============================================================================
package lc3b_types;

  // Architectural register index (R0..R7)
  typedef logic [2:0] lc3b_reg;

  // Control word carried down the pipeline registers
  typedef struct packed {
    logic [3:0] opcode;
    logic       load_regfile;
    logic       mem_read;
    logic       mem_write;
    logic       load_cc;
    logic       br_en;
    lc3b_reg    dest;
  } lc3b_control_word;

  // A NOP writes nothing and touches no memory, so all-zero is safe
  localparam lc3b_control_word c_nop_ctrl = '0;

  // Hazard controller states
  typedef enum logic [1:0] {
    HZ_RUN        = 2'd0,
    HZ_DMEM_WAIT  = 2'd1,
    HZ_IMEM_DRAIN = 2'd2
  } lc3b_hz_state;

  // Pipeline enables / flushes produced each cycle
  typedef struct packed {
    logic pc_load;
    logic ifid_load;
    logic idex_load;
    logic exmem_load;
    logic memwb_load;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
    logic idex_bubble;
    logic redirect_pending;
  } lc3b_hz_ctrl;

  // Default "everything advances" control bundle
  localparam lc3b_hz_ctrl c_ctl_advance = '{
    pc_load: 1'b1, ifid_load: 1'b1, idex_load: 1'b1, exmem_load: 1'b1,
    memwb_load: 1'b1, ifid_flush: 1'b0, idex_flush: 1'b0, exmem_flush: 1'b0,
    idex_bubble: 1'b0, redirect_pending: 1'b0
  };

  // True when a source operand is really read and matches the destination
  function automatic logic lc3b_src_match(input logic uses, input lc3b_reg sr,
                                          input lc3b_reg dest);
    return uses && (sr == dest);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lc3b_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : lc3b_sat_counter
// Purpose  : Saturating up-counter with synchronous clear and async reset.
// Revision : 1.0 - initial release
// ============================================================================
module lc3b_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  localparam logic [WIDTH-1:0] c_max = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] c_one = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] count_q;

  // Next count: clear wins, otherwise increment until all-ones then hold
  always_comb begin
    count_d = count_q;
    if (i_clr) begin
      count_d = '0;
    end else if (i_inc && (count_q != c_max)) begin
      count_d = count_q + c_one;
    end
  end

  // Count register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_count = count_q;

endmodule
`default_nettype wire

// File: rtl/lc3b_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lc3b_hazard_ctrl
// Purpose  : Five-stage LC-3b hazard/stall controller. Freezes the pipe on
//            data-memory waits, flushes on taken branches, inserts load-use
//            bubbles, holds fetch on I-miss and counts stalls/flushes.
// Revision : 1.0 - initial release
// ============================================================================
module lc3b_hazard_ctrl
  import lc3b_types::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       ifid_sr1,
  input  logic [2:0]       ifid_sr2,
  input  logic             ifid_uses_sr1,
  input  logic             ifid_uses_sr2,
  input  logic [2:0]       idex_dest,
  input  logic             idex_load_regfile,
  input  logic             idex_mem_read,
  input  logic             exmem_mem_req,
  input  logic             dmem_resp,
  input  logic             imem_resp,
  input  logic             br_taken,
  output logic             pc_load,
  output logic             ifid_load,
  output logic             idex_load,
  output logic             exmem_load,
  output logic             memwb_load,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             idex_bubble,
  output logic             redirect_pending,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  lc3b_hz_state state_d;
  lc3b_hz_state state_q;

  lc3b_hz_ctrl  w_ctl;
  lc3b_hz_ctrl  w_ctl_out;
  logic         w_freeze;
  logic         w_load_use;
  logic         w_br_accept;

  assign w_freeze   = exmem_mem_req && !dmem_resp;
  assign w_load_use = idex_mem_read && idex_load_regfile &&
                      (lc3b_src_match(ifid_uses_sr1, ifid_sr1, idex_dest) ||
                       lc3b_src_match(ifid_uses_sr2, ifid_sr2, idex_dest));

  // State register; reset abandons any pending drain or freeze
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= HZ_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: freeze dominates, a taken branch that misses fetch drains
  always_comb begin
    state_d = state_q;
    case (state_q)
      HZ_RUN, HZ_DMEM_WAIT: begin
        if (w_freeze) begin
          state_d = HZ_DMEM_WAIT;
        end else if (br_taken && !imem_resp) begin
          state_d = HZ_IMEM_DRAIN;
        end else begin
          state_d = HZ_RUN;
        end
      end
      HZ_IMEM_DRAIN: begin
        if (imem_resp) begin
          state_d = HZ_RUN;
        end
      end
      default: state_d = HZ_RUN;
    endcase
  end

  // Outputs: prioritised freeze > branch > load-use > fetch wait
  always_comb begin
    w_ctl       = c_ctl_advance;
    w_br_accept = 1'b0;
    case (state_q)
      HZ_RUN, HZ_DMEM_WAIT: begin
        if (w_freeze) begin
          w_ctl = '0;
        end else if (br_taken) begin
          w_br_accept       = 1'b1;
          w_ctl.ifid_flush  = 1'b1;
          w_ctl.idex_flush  = 1'b1;
          w_ctl.exmem_flush = 1'b1;
          if (imem_resp) begin
            w_ctl.redirect_pending = 1'b1;
          end else begin
            w_ctl.pc_load = 1'b0;
          end
        end else if (w_load_use) begin
          w_ctl.pc_load     = 1'b0;
          w_ctl.ifid_load   = 1'b0;
          w_ctl.idex_bubble = 1'b1;
        end else if (!imem_resp) begin
          w_ctl.pc_load    = 1'b0;
          w_ctl.ifid_flush = 1'b1;
        end
      end
      HZ_IMEM_DRAIN: begin
        // Wrong-path word is discarded; PC waits for the redirect fetch
        w_ctl.redirect_pending = 1'b1;
        w_ctl.ifid_flush       = 1'b1;
        w_ctl.pc_load          = imem_resp;
      end
      default: w_ctl = c_ctl_advance;
    endcase
  end

  // Everything is held inactive while reset is asserted
  assign w_ctl_out = reset_n ? w_ctl : '0;

  assign pc_load          = w_ctl_out.pc_load;
  assign ifid_load        = w_ctl_out.ifid_load;
  assign idex_load        = w_ctl_out.idex_load;
  assign exmem_load       = w_ctl_out.exmem_load;
  assign memwb_load       = w_ctl_out.memwb_load;
  assign ifid_flush       = w_ctl_out.ifid_flush;
  assign idex_flush       = w_ctl_out.idex_flush;
  assign exmem_flush      = w_ctl_out.exmem_flush;
  assign idex_bubble      = w_ctl_out.idex_bubble;
  assign redirect_pending = w_ctl_out.redirect_pending;

  lc3b_sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clr   (1'b0),
    .i_inc   (reset_n && !w_ctl_out.pc_load),
    .o_count (stall_cycles)
  );

  lc3b_sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clr   (1'b0),
    .i_inc   (reset_n && w_br_accept),
    .o_count (flush_count)
  );

endmodule
`default_nettype wire

// File: tb/tb_lc3b_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lc3b_hazard_ctrl
// Purpose  : Scoreboard bench for lc3b_hazard_ctrl with directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lc3b_hazard_ctrl;
  import lc3b_types::*;

  localparam int CNT_W = 16;

  // {pc, ifid, idex, exmem, memwb, ifid_fl, idex_fl, exmem_fl, bubble, redirect}
  localparam logic [9:0] RST        = 10'b00000_000_0_0;
  localparam logic [9:0] IDLE       = 10'b11111_000_0_0;
  localparam logic [9:0] LU         = 10'b00111_000_1_0;
  localparam logic [9:0] FRZ        = 10'b00000_000_0_0;
  localparam logic [9:0] BR_OK      = 10'b11111_111_0_1;
  localparam logic [9:0] BR_MISS    = 10'b01111_111_0_0;
  localparam logic [9:0] DRAIN_WAIT = 10'b01111_100_0_1;
  localparam logic [9:0] DRAIN_DONE = 10'b11111_100_0_1;
  localparam logic [9:0] FETCH_WAIT = 10'b01111_100_0_0;

  logic clk = 1'b0;
  logic reset_n;
  logic [2:0] ifid_sr1, ifid_sr2, idex_dest;
  logic ifid_uses_sr1, ifid_uses_sr2, idex_load_regfile, idex_mem_read;
  logic exmem_mem_req, dmem_resp, imem_resp, br_taken;
  logic pc_load, ifid_load, idex_load, exmem_load, memwb_load;
  logic ifid_flush, idex_flush, exmem_flush, idex_bubble, redirect_pending;
  logic [CNT_W-1:0] stall_cycles, flush_count;

  always #5 clk = ~clk;

  lc3b_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .ifid_sr1          (ifid_sr1),
    .ifid_sr2          (ifid_sr2),
    .ifid_uses_sr1     (ifid_uses_sr1),
    .ifid_uses_sr2     (ifid_uses_sr2),
    .idex_dest         (idex_dest),
    .idex_load_regfile (idex_load_regfile),
    .idex_mem_read     (idex_mem_read),
    .exmem_mem_req     (exmem_mem_req),
    .dmem_resp         (dmem_resp),
    .imem_resp         (imem_resp),
    .br_taken          (br_taken),
    .pc_load           (pc_load),
    .ifid_load         (ifid_load),
    .idex_load         (idex_load),
    .exmem_load        (exmem_load),
    .memwb_load        (memwb_load),
    .ifid_flush        (ifid_flush),
    .idex_flush        (idex_flush),
    .exmem_flush       (exmem_flush),
    .idex_bubble       (idex_bubble),
    .redirect_pending  (redirect_pending),
    .stall_cycles      (stall_cycles),
    .flush_count       (flush_count)
  );

  typedef struct {
    logic [9:0]       ctl;
    logic [CNT_W-1:0] stall;
    logic [CNT_W-1:0] flush;
    string            name;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [9:0] act_ctl;
  assign act_ctl = {pc_load, ifid_load, idex_load, exmem_load, memwb_load,
                    ifid_flush, idex_flush, exmem_flush, idex_bubble, redirect_pending};

  // Branches may only resolve while the controller is in RUN
  always @(posedge clk) begin
    if (reset_n && br_taken) begin
      assert (dut.state_q == HZ_RUN) else $error("br_taken seen outside RUN");
    end
  end

  // Monitor: one expected entry per cycle, compared mid-cycle
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_cmp++;
      if (act_ctl !== e.ctl || stall_cycles !== e.stall || flush_count !== e.flush) begin
        n_bad++;
        $display("FAIL %s: got ctl=%b stall=%h flush=%h, want ctl=%b stall=%h flush=%h",
                 e.name, act_ctl, stall_cycles, flush_count, e.ctl, e.stall, e.flush);
      end
    end
  end

  task automatic push(input logic [9:0] ctl, input logic [CNT_W-1:0] s,
                      input logic [CNT_W-1:0] f, input string name);
    exp_t e;
    e.ctl = ctl; e.stall = s; e.flush = f; e.name = name;
    sb.push_back(e);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ifid_sr1 = 3'd1; ifid_sr2 = 3'd2; ifid_uses_sr1 = 1'b0; ifid_uses_sr2 = 1'b0;
    idex_dest = 3'd5; idex_load_regfile = 1'b0; idex_mem_read = 1'b0;
    exmem_mem_req = 1'b0; dmem_resp = 1'b1; imem_resp = 1'b1; br_taken = 1'b0;
  endtask

  // LDR R3 in ID/EX, consumer reads R3 through sr1
  task automatic lu1();
    idex_dest = 3'd3; idex_mem_read = 1'b1; idex_load_regfile = 1'b1;
    ifid_sr1 = 3'd3; ifid_uses_sr1 = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    idle();
    next(); push(RST, 16'd0, 16'd0, "reset");
    next(); reset_n = 1'b1; push(IDLE, 16'd0, 16'd0, "idle");

    // Load-use and false-hazard filtering
    next(); lu1(); push(LU, 16'd0, 16'd0, "lu_sr1");
    next(); idle(); push(IDLE, 16'd1, 16'd0, "lu_release");
    next(); lu1(); ifid_uses_sr1 = 1'b0; push(IDLE, 16'd1, 16'd0, "no_hz_unused_src");
    next(); lu1(); idex_mem_read = 1'b0; push(IDLE, 16'd1, 16'd0, "no_hz_not_load");
    next(); idle(); idex_dest = 3'd6; idex_mem_read = 1'b1; idex_load_regfile = 1'b1;
    ifid_sr2 = 3'd6; ifid_uses_sr2 = 1'b1; push(LU, 16'd1, 16'd0, "lu_sr2");
    next(); idle(); push(IDLE, 16'd2, 16'd0, "lu2_release");

    // Data-memory freeze with a load-use hazard underneath
    for (int i = 0; i < 4; i++) begin
      next(); lu1(); exmem_mem_req = 1'b1; dmem_resp = 1'b0;
      push(FRZ, 16'(2 + i), 16'd0, "dmem_freeze");
    end
    next(); lu1(); exmem_mem_req = 1'b1; dmem_resp = 1'b1; push(LU, 16'd6, 16'd0, "freeze_resp_lu");
    next(); idle(); push(IDLE, 16'd7, 16'd0, "post_freeze");

    // Taken branch with fetch ready
    next(); idle(); br_taken = 1'b1; push(BR_OK, 16'd7, 16'd0, "br_hit");
    next(); idle(); push(IDLE, 16'd7, 16'd1, "post_br_hit");

    // Taken branch during a fetch miss, with load-use masked in the drain
    next(); idle(); br_taken = 1'b1; imem_resp = 1'b0; push(BR_MISS, 16'd7, 16'd1, "br_miss");
    for (int i = 0; i < 3; i++) begin
      next(); idle(); lu1(); imem_resp = 1'b0;
      push(DRAIN_WAIT, 16'(8 + i), 16'd2, "drain_wait");
    end
    next(); idle(); push(DRAIN_DONE, 16'd11, 16'd2, "drain_done");
    next(); idle(); push(IDLE, 16'd11, 16'd2, "post_drain");
    next(); idle(); imem_resp = 1'b0; push(FETCH_WAIT, 16'd11, 16'd2, "fetch_wait");
    next(); idle(); push(IDLE, 16'd12, 16'd2, "post_fetch_wait");

    // Async reset in the middle of a drain
    next(); idle(); br_taken = 1'b1; imem_resp = 1'b0; push(BR_MISS, 16'd12, 16'd2, "br_miss2");
    next(); idle(); imem_resp = 1'b0; push(DRAIN_WAIT, 16'd13, 16'd3, "drain2");
    next(); idle(); imem_resp = 1'b0; #1 reset_n = 1'b0; push(RST, 16'd0, 16'd0, "rst_async");
    next(); push(RST, 16'd0, 16'd0, "rst_hold");
    next(); reset_n = 1'b1; push(FETCH_WAIT, 16'd0, 16'd0, "rst_release_run");
    next(); idle(); push(IDLE, 16'd1, 16'd0, "rst_release_idle");

    // Walk stall_cycles up to 0xFFFE, then check saturation
    for (int i = 0; i < 65533; i++) begin
      next(); imem_resp = 1'b0;
    end
    next(); imem_resp = 1'b0; push(FETCH_WAIT, 16'hFFFE, 16'd0, "sat_fffe");
    next(); push(FETCH_WAIT, 16'hFFFF, 16'd0, "sat_ffff");
    next(); push(FETCH_WAIT, 16'hFFFF, 16'd0, "sat_hold");
    next(); idle(); push(IDLE, 16'hFFFF, 16'd0, "sat_final");

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
